// File: rtl/sw_event_encoder_pkg.sv
// Shared event-word layout, FSM encoding and parameter defaults for the
// switch/button event encoder.
package sw_event_encoder_pkg;

  localparam int EVT_W        = 8;
  localparam int EVT_TYPE_LSB = 6;
  localparam int EVT_IDX_LSB  = 1;
  localparam int EVT_IDX_W    = 5;

  localparam int DEF_WIDTH_SWITCHES  = 8;
  localparam int DEF_WIDTH_BUTTONS   = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;

  typedef enum logic [1:0] {
    EVT_SWITCH  = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_RSVD    = 2'b11
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_IDLE  = 2'b01,
    ST_WRITE = 2'b10
  } state_e;

  function automatic logic [EVT_W-1:0] make_event(
    input evt_type_e             evt_type,
    input logic [EVT_IDX_W-1:0]  idx,
    input logic                  val
  );
    logic [EVT_W-1:0] w;
    w = '0;
    w[EVT_TYPE_LSB +: 2]        = evt_type;
    w[EVT_IDX_LSB +: EVT_IDX_W] = idx;
    w[0]                        = val;
    return w;
  endfunction

endpackage

// File: rtl/sw_debouncer.sv
// Two-flop synchronizer plus 3-sample history per input; the debounced level
// follows the history only when all three samples agree.
module sw_debouncer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] deb
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] h0_q, h0_d;
  logic [WIDTH-1:0] h1_q, h1_d;
  logic [WIDTH-1:0] h2_q, h2_d;
  logic [WIDTH-1:0] deb_q, deb_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    h0_d    = h0_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    if (tick) begin
      h0_d = sync2_q;
      h1_d = h0_q;
      h2_d = h1_q;
    end
  end

  // Stability is judged on the post-shift history so deb moves on the tick edge.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stable
      assign deb_d[gi] = (h0_d[gi] == h1_d[gi] && h1_d[gi] == h2_d[gi]) ? h0_d[gi] : deb_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
      deb_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      deb_q   <= deb_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/sw_event_encoder.sv
// Debounces switches and buttons, queues every debounced edge in a pending mask
// and writes one 8-bit event word per edge into a downstream FIFO.
module sw_event_encoder
  import sw_event_encoder_pkg::*;
#(
  parameter int WIDTH_SWITCHES  = DEF_WIDTH_SWITCHES,
  parameter int WIDTH_BUTTONS   = DEF_WIDTH_BUTTONS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WIDTH_EVENT     = EVT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH_SWITCHES-1:0] switches,
  input  logic [WIDTH_BUTTONS-1:0]  buttons,
  input  logic                      fifo_full,
  output logic [WIDTH_EVENT-1:0]    wr_data,
  output logic                      wr_en,
  output logic [WIDTH_SWITCHES-1:0] sw_state,
  output logic [7:0]                dropped_events
);

  localparam int NUM_IN = WIDTH_SWITCHES + WIDTH_BUTTONS;
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      tick_q, tick_d;
  state_e                    state_q, state_d;
  logic [1:0]                init_ticks_q, init_ticks_d;
  logic [NUM_IN-1:0]         known_q, known_d;
  logic [NUM_IN-1:0]         pending_q, pending_d;
  logic [WIDTH_EVENT-1:0]    wr_data_q, wr_data_d;
  logic                      wr_en_q, wr_en_d;
  logic [7:0]                dropped_q, dropped_d;

  logic [WIDTH_SWITCHES-1:0] sw_deb;
  logic [WIDTH_BUTTONS-1:0]  btn_deb;
  logic [NUM_IN-1:0]         deb_all;
  logic [NUM_IN-1:0]         chg, sel_oh, grant, cancel;
  logic                      do_sel;
  logic [EVT_IDX_W-1:0]      sel_idx;
  logic                      sel_val, sel_btn;
  logic [5:0]                drop_cnt;
  logic [8:0]                drop_sum;

  sw_debouncer #(.WIDTH(WIDTH_SWITCHES)) u_sw_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_q),
    .raw   (switches),
    .deb   (sw_deb)
  );

  sw_debouncer #(.WIDTH(WIDTH_BUTTONS)) u_btn_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_q),
    .raw   (buttons),
    .deb   (btn_deb)
  );

  assign deb_all = {btn_deb, sw_deb};

  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_q == CNT_MAX);
  end

  // Pending mask: each debounced edge toggles its bit; a granted bit is cleared
  // first so an edge landing on the grant cycle re-queues rather than cancels.
  always_comb begin
    known_d   = deb_all;
    chg       = (state_q == ST_INIT) ? '0 : (deb_all ^ known_q);
    do_sel    = (state_q == ST_IDLE) && !fifo_full && (|pending_q);
    sel_oh    = pending_q & (~pending_q + NUM_IN'(1));
    grant     = do_sel ? sel_oh : '0;
    cancel    = pending_q & ~grant & chg;
    pending_d = (pending_q & ~grant) ^ chg;

    sel_idx = '0;
    sel_val = 1'b0;
    sel_btn = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx = EVT_IDX_W'(i);
        sel_val = deb_all[i];
        sel_btn = (i >= WIDTH_SWITCHES);
      end
    end

    drop_cnt = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      drop_cnt = drop_cnt + 6'(cancel[i]);
    end
    drop_sum  = {1'b0, dropped_q} + 9'(drop_cnt);
    dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    state_d      = state_q;
    init_ticks_d = init_ticks_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    case (state_q)
      ST_INIT: begin
        if (init_ticks_q == 2'd3) begin
          state_d = ST_IDLE;
        end else if (tick_q) begin
          init_ticks_d = init_ticks_q + 2'd1;
        end
      end
      ST_IDLE: begin
        if (do_sel) begin
          wr_data_d = make_event(sel_btn ? (sel_val ? EVT_PRESS : EVT_RELEASE) : EVT_SWITCH,
                                 sel_idx, sel_val);
          wr_en_d   = 1'b1;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      state_q      <= ST_INIT;
      init_ticks_q <= '0;
      known_q      <= '0;
      pending_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      dropped_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      state_q      <= state_d;
      init_ticks_q <= init_ticks_d;
      known_q      <= known_d;
      pending_q    <= pending_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      dropped_q    <= dropped_d;
    end
  end

  assign wr_data        = wr_data_q;
  assign wr_en          = wr_en_q;
  assign sw_state       = known_q[WIDTH_SWITCHES-1:0];
  assign dropped_events = dropped_q;

endmodule

// File: tb/tb_sw_event_encoder.sv
// Randomized bench for sw_event_encoder: inputs move in whole debounce periods,
// a step-level model predicts debounced edges, events, cancellations and drops.
module tb_sw_event_encoder;

  localparam int N  = 4;
  localparam int WS = 8;
  localparam int WB = 4;
  localparam int NI = WS + WB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WS-1:0] switches;
  logic [WB-1:0] buttons;
  logic          fifo_full;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic [WS-1:0] sw_state;
  logic [7:0]    dropped_events;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int b2b = 0;
  logic wr_en_prev = 1'b0;
  logic [7:0] wq[$];
  int         wt[$];

  logic [NI-1:0] steps_q[$];
  logic [NI-1:0] m_deb;
  logic [NI-1:0] cur;
  int            m_trans[NI];
  int            m_drop = 0;

  sw_event_encoder #(
    .WIDTH_SWITCHES  (WS),
    .WIDTH_BUTTONS   (WB),
    .DEBOUNCE_CYCLES (N),
    .WIDTH_EVENT     (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .switches       (switches),
    .buttons        (buttons),
    .fifo_full      (fifo_full),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .sw_state       (sw_state),
    .dropped_events (dropped_events)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wq.push_back(wr_data);
      wt.push_back(cyc);
      if (wr_en_prev) b2b <= b2b + 1;
    end
    wr_en_prev <= wr_en;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  function automatic logic [7:0] evt(input int idx, input logic v);
    logic [1:0] t;
    logic [4:0] ix;
    ix = 5'(idx);
    if (idx < WS) t = 2'b00;
    else          t = v ? 2'b01 : 2'b10;
    return {t, ix, v};
  endfunction

  // One step = one debounce period with the inputs held constant.
  task automatic step(input logic [NI-1:0] v);
    steps_q.push_back(v);
    if (steps_q.size() > 3) void'(steps_q.pop_front());
    if (steps_q.size() == 3) begin
      for (int i = 0; i < NI; i++) begin
        if (steps_q[0][i] == v[i] && steps_q[1][i] == v[i] && m_deb[i] != v[i]) begin
          m_deb[i] = v[i];
          m_trans[i]++;
        end
      end
    end
    {buttons, switches} = v;
    cur = v;
    repeat (N) @(negedge clk);
    #2;
  endtask

  task automatic begin_round(input logic full);
    wq.delete();
    wt.delete();
    fifo_full = full;
  endtask

  task automatic settle(input string tag);
    logic [7:0] exp_q[$];
    repeat (3) step(cur);
    if (fifo_full) begin
      check_value({tag, "_held"}, wq.size(), 0);
      fifo_full = 1'b0;
    end
    repeat (40) @(negedge clk);
    #2;
    for (int i = 0; i < NI; i++) begin
      if (m_trans[i] % 2 == 1) exp_q.push_back(evt(i, m_deb[i]));
      m_drop += m_trans[i] / 2;
      m_trans[i] = 0;
    end
    if (m_drop > 255) m_drop = 255;
    check_value({tag, "_count"}, wq.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      check_value($sformatf("%s_ev%0d", tag, k),
                  (k < wq.size()) ? 32'(wq[k]) : 32'hFFFF_FFFF, 32'(exp_q[k]));
    end
    check_value({tag, "_drop"}, dropped_events, m_drop);
    check_value({tag, "_sw"}, sw_state, m_deb[WS-1:0]);
    check_value({tag, "_b2b"}, b2b, 0);
  endtask

  initial begin
    logic          full;
    int            nseg;
    int            g;
    int            h;
    logic [NI-1:0] mask;
    logic          found;

    for (int i = 0; i < NI; i++) m_trans[i] = 0;
    switches  = 8'h05;
    buttons   = '0;
    fifo_full = 1'b0;
    rst_n     = 1'b0;
    cur       = 12'h005;
    m_deb     = 12'h005;

    repeat (3) @(negedge clk);
    #1;
    check_value("rst_wr_en", wr_en, 0);
    check_value("rst_wr_data", wr_data, 0);
    check_value("rst_sw_state", sw_state, 0);
    check_value("rst_dropped", dropped_events, 0);
    #1;
    rst_n = 1'b1;

    // INIT loads the power-up levels silently.
    repeat (6) step(12'h005);
    check_value("init_no_write", wq.size(), 0);
    check_value("init_sw_state", sw_state, 8'h05);
    check_value("init_dropped", dropped_events, 0);

    begin_round(1'b0);
    repeat (3) step(12'h00D);
    settle("sw3");
    check_value("sw3_word", (wq.size() > 0) ? 32'(wq[0]) : 32'hFFFF_FFFF, 8'h07);

    begin_round(1'b0);
    repeat (3) step(12'h20D);
    settle("btn1_press");
    check_value("btn1_press_word", (wq.size() > 0) ? 32'(wq[0]) : 32'hFFFF_FFFF, 8'h53);
    begin_round(1'b0);
    repeat (3) step(12'h00D);
    settle("btn1_rel");
    check_value("btn1_rel_word", (wq.size() > 0) ? 32'(wq[0]) : 32'hFFFF_FFFF, 8'h92);

    begin_round(1'b0);
    repeat (3) step(12'h008);
    settle("sw02_fall");
    begin_round(1'b1);
    repeat (3) step(12'h00D);
    settle("sw02_full");
    check_value("full_first", (wq.size() > 0) ? 32'(wq[0]) : 32'hFFFF_FFFF, 8'h01);
    check_value("full_second", (wq.size() > 1) ? 32'(wq[1]) : 32'hFFFF_FFFF, 8'h05);
    check_value("full_gap", (wt.size() > 1) ? 32'(wt[1] - wt[0]) : 32'hFFFF_FFFF, 2);

    begin_round(1'b1);
    repeat (3) step(12'h04D);
    repeat (3) step(12'h00D);
    settle("sw6_cancel");
    check_value("sw6_dropped", dropped_events, 1);

    begin_round(1'b0);
    step(12'h01D);
    step(12'h00D);
    settle("sw4_glitch");

    for (int r = 0; r < 20; r++) begin
      full = 1'($urandom_range(0, 1));
      nseg = full ? $urandom_range(1, 3) : 1;
      begin_round(full);
      for (int s = 0; s < nseg; s++) begin
        if ($urandom_range(0, 2) == 0) begin
          g    = $urandom_range(1, 2);
          mask = NI'($urandom) | (NI'(1) << $urandom_range(0, NI - 1));
          mask = cur ^ mask;
          repeat (g) step(mask);
          step(steps_q[0]);
        end
        mask = cur ^ NI'($urandom);
        h    = $urandom_range(3, 5);
        repeat (h) step(mask);
      end
      settle($sformatf("rnd%0d", r));
    end

    // Asynchronous reset while a write strobe is on the bus.
    wq.delete();
    {buttons, switches} = cur ^ 12'h080;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (wr_en) found = 1'b1;
    end
    check_value("rst_wr_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check_value("midwr_wr_en", wr_en, 0);
    check_value("midwr_wr_data", wr_data, 0);
    check_value("midwr_sw_state", sw_state, 0);
    check_value("midwr_dropped", dropped_events, 0);
    repeat (3) @(negedge clk);
    #2;
    wq.delete();
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #2;
    check_value("post_rst_no_write", wq.size(), 0);
    check_value("post_rst_sw_state", sw_state, switches);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
